mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction read port and a data read/write port onto a byte-wide RAM.
// Define MEMCTRL_DPRIO_EN to let the data port win simultaneous requests; otherwise the instruction port wins.
module mem_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic        i_busy,
    output logic        i_ready,
    output logic [31:0] i_data,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_len,
    output logic        d_busy,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din
);

    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [1:0]  last, last_nx;
    logic        tail, tail_nx;
    logic        dport, dport_nx;
    logic [31:0] addr, addr_nx;
    logic [31:0] wdata, wdata_nx;
    logic        take_i, take_d;
    logic        reading;
    logic        rd_pend;
    logic [1:0]  rd_idx;
    logic [31:0] rd_buf, merged;
    logic        busy;

`ifdef MEMCTRL_DPRIO_EN
    assign take_d = d_read | d_write;
    assign take_i = i_read & ~take_d;
`else
    assign take_i = i_read;
    assign take_d = (d_read | d_write) & ~i_read;
`endif

    assign reading = (state == IREAD) || (state == DREAD);

    // tail marks the extra read cycle that captures the last byte after all addresses went out
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        tail_nx  = tail;
        dport_nx = dport;
        addr_nx  = addr;
        wdata_nx = wdata;
        case (state)
            IDLE: begin
                cnt_nx  = 2'd0;
                tail_nx = 1'b0;
                if (take_i) begin
                    state_nx = IREAD;
                    dport_nx = 1'b0;
                    addr_nx  = i_addr;
                    last_nx  = 2'd3;
                end else if (take_d) begin
                    state_nx = d_write ? DWRITE : DREAD;
                    dport_nx = 1'b1;
                    addr_nx  = d_addr;
                    wdata_nx = d_wdata;
                    last_nx  = d_len[1] ? 2'd3 : {1'b0, d_len[0]};
                end
            end
            IREAD, DREAD: begin
                if (tail)             state_nx = DONE;
                else if (cnt == last) tail_nx  = 1'b1;
                else                  cnt_nx   = cnt + 2'd1;
            end
            DWRITE: begin
                if (cnt == last) state_nx = DONE;
                else             cnt_nx   = cnt + 2'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            last  <= 2'd0;
            tail  <= 1'b0;
            dport <= 1'b0;
            addr  <= 32'd0;
            wdata <= 32'd0;
            busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
            tail  <= tail_nx;
            dport <= dport_nx;
            addr  <= addr_nx;
            wdata <= wdata_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    // RAM data lags its address by one cycle, so the capture index trails the address counter
    always_comb begin
        merged = rd_buf;
        merged[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            rd_idx  <= 2'd0;
            rd_buf  <= 32'd0;
            i_data  <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            rd_pend <= reading && !tail;
            rd_idx  <= cnt;
            if (state == IDLE) rd_buf <= 32'd0;
            else if (rd_pend)  rd_buf <= merged;
            if (reading && tail) begin
                if (state == IREAD) i_data  <= merged;
                else                d_rdata <= merged;
            end
        end
    end

    assign i_busy  = busy;
    assign d_busy  = busy;
    assign i_ready = (state == DONE) && !dport;
    assign d_ready = (state == DONE) && dport;

    always_comb begin
        mem_addr = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (state)
            IREAD, DREAD: begin
                if (!tail) mem_addr = addr + {30'd0, cnt};
            end
            DWRITE: begin
                mem_addr = addr + {30'd0, cnt};
                mem_dout = wdata[{cnt, 3'b000} +: 8];
                mem_wr   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-level reference model checked every cycle, plus directed literal checks.
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_busy, i_ready;
    logic [31:0] i_data;
    logic        d_read = 1'b0, d_write = 1'b0;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic [1:0]  d_len = 2'd0;
    logic        d_busy, d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = 8'd0;

    mem_ctrl dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_busy(i_busy), .i_ready(i_ready), .i_data(i_data),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
        .d_busy(d_busy), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // RAM seen by the DUT and the model's own copy of what RAM should hold
    logic [7:0] ram [bit [31:0]];
    logic [7:0] mm  [bit [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] mm_rd(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        mm[a]  = v;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            if (mem_wr) ram[mem_addr] = mem_dout;
            mem_din <= ram_rd(mem_addr);
        end
    end

    // Reference model: a transaction lasts n+2 cycles (read) or n+1 cycles (write) after its sampling edge
    int          m_kind = 0;   // 0 instruction read, 1 data read, 2 data write
    bit          m_act = 1'b0;
    int          m_c = 0, m_n = 0, m_last = 0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0, m_res = 32'd0;
    logic [31:0] e_idata = 32'd0, e_drdata = 32'd0, e_addr = 32'd0;
    logic [7:0]  e_dout = 8'd0;
    bit          e_busy = 1'b0, e_iready = 1'b0, e_dready = 1'b0, e_wr = 1'b0;
    bit          chk_addr = 1'b1, chk_dout = 1'b1;
    bit          pick_i;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_act = 1'b0;
                m_c = 0;
                e_idata = 32'd0;
                e_drdata = 32'd0;
            end else if (m_act) begin
                if (m_kind == 2 && m_c <= m_n) mm[m_addr + 32'(m_c - 1)] = 8'((m_wdata >> (8 * (m_c - 1))) & 32'hFF);
                m_c++;
                if (m_c > m_last) m_act = 1'b0;
                else if (m_c == m_last && m_kind == 0) e_idata = m_res;
                else if (m_c == m_last && m_kind == 1) e_drdata = m_res;
            end else if (i_read || d_read || d_write) begin
`ifdef MEMCTRL_DPRIO_EN
                pick_i = !(d_read || d_write);
`else
                pick_i = i_read;
`endif
                if (pick_i) begin
                    m_kind = 0; m_addr = i_addr; m_n = 4;
                end else begin
                    m_kind = d_write ? 2 : 1; m_addr = d_addr; m_wdata = d_wdata;
                    m_n = (d_len == 2'd0) ? 1 : (d_len == 2'd1) ? 2 : 4;
                end
                m_last = (m_kind == 2) ? m_n + 1 : m_n + 2;
                m_res = 32'd0;
                for (int i = 0; i < m_n; i++) m_res = m_res | (32'(mm_rd(m_addr + 32'(i))) << (8 * i));
                m_act = 1'b1;
                m_c = 1;
            end
            e_busy   = m_act;
            e_iready = m_act && m_c == m_last && m_kind == 0;
            e_dready = m_act && m_c == m_last && m_kind != 0;
            e_wr     = m_act && m_kind == 2 && m_c <= m_n;
            chk_addr = !m_act || m_c <= m_n;
            e_addr   = m_act ? m_addr + 32'(m_c - 1) : 32'd0;
            chk_dout = !m_act || e_wr;
            e_dout   = e_wr ? 8'((m_wdata >> (8 * (m_c - 1))) & 32'hFF) : 8'd0;
        end
    end

    bit run_cmp = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (run_cmp) begin
                check("i_busy", {31'd0, i_busy}, {31'd0, e_busy});
                check("d_busy", {31'd0, d_busy}, {31'd0, e_busy});
                check("i_ready", {31'd0, i_ready}, {31'd0, e_iready});
                check("d_ready", {31'd0, d_ready}, {31'd0, e_dready});
                check("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
                check("i_data", i_data, e_idata);
                check("d_rdata", d_rdata, e_drdata);
                if (chk_addr) check("mem_addr", mem_addr, e_addr);
                if (chk_dout) check("mem_dout", {24'd0, mem_dout}, {24'd0, e_dout});
            end
        end
    end

    logic [31:0] seen_addr [1:15];
    logic        seen_wr   [1:15];
    logic [7:0]  seen_dout [1:15];

    // Raise one request set, watch the chosen port's ready pulse, then drop all requests
    task automatic txn(input logic ir, input logic dr, input logic dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input logic [1:0] len,
                       input bit mutate, output int rc);
        @(negedge clock); #1;
        i_read = ir; d_read = dr; d_write = dw;
        i_addr = ia; d_addr = da; d_wdata = wd; d_len = len;
        rc = 0;
        for (int k = 1; k <= 40 && rc == 0; k++) begin
            @(negedge clock);
            if (k < 16) begin
                seen_addr[k] = mem_addr; seen_wr[k] = mem_wr; seen_dout[k] = mem_dout;
            end
            if ((ir && i_ready) || (!ir && d_ready)) rc = k;
            if (mutate && k == 1) begin
                #1; i_addr = 32'h0BAD_0000; d_addr = 32'h0000_5000; d_wdata = 32'd0; d_len = 2'd2;
            end
        end
        #1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        check("ready_seen", {31'd0, rc != 0}, 32'd1);
    endtask

    int rc, ci, cd;

    initial begin
        preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        preload(32'h104, 8'h55); preload(32'h105, 8'h66); preload(32'h106, 8'h77); preload(32'h107, 8'h88);
        preload(32'h7, 8'h80);   preload(32'h2002, 8'h5A);
        preload(32'hFFFF_FFFE, 8'hF0); preload(32'hFFFF_FFFF, 8'hE1); preload(32'h0, 8'hE2);

        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, i_busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        #1; reset = 1'b1;
        run_cmp = 1'b1;
        repeat (2) @(negedge clock);

        // word instruction read
        txn(1, 0, 0, 32'h100, 0, 0, 2'd0, 1, rc);
        check("ird_ready_cycle", rc, 6);
        for (int k = 1; k <= 4; k++) check("ird_addr", seen_addr[k], 32'h100 + 32'(k - 1));
        check("ird_data", i_data, 32'h4433_2211);

        // half write; inputs scrambled after sampling must not matter
        txn(0, 0, 1, 0, 32'h2000, 32'hAABB_CCDD, 2'd1, 1, rc);
        check("hw_ready_cycle", rc, 3);
        check("hw_wr1", {31'd0, seen_wr[1]}, 32'd1);
        check("hw_wr2", {31'd0, seen_wr[2]}, 32'd1);
        check("hw_ram0", {24'd0, ram_rd(32'h2000)}, 32'hDD);
        check("hw_ram1", {24'd0, ram_rd(32'h2001)}, 32'hCC);
        check("hw_ram2", {24'd0, ram_rd(32'h2002)}, 32'h5A);

        // byte read zero-extends
        txn(0, 1, 0, 0, 32'h7, 0, 2'd0, 0, rc);
        check("br_ready_cycle", rc, 3);
        check("br_data", d_rdata, 32'h0000_0080);

        // read+write together is a word write; read it back with len 11
        txn(0, 1, 1, 0, 32'h3000, 32'h0102_0304, 2'd2, 0, rc);
        check("ww_ready_cycle", rc, 5);
        check("ww_ram3", {24'd0, ram_rd(32'h3003)}, 32'h01);
        txn(0, 1, 0, 0, 32'h3000, 0, 2'd3, 0, rc);
        check("wr_ready_cycle", rc, 6);
        check("wr_data", d_rdata, 32'h0102_0304);

        // address wrap on instruction and data sides
        txn(1, 0, 0, 32'hFFFF_FFFE, 0, 0, 2'd0, 0, rc);
        check("wrap_addr1", seen_addr[1], 32'hFFFF_FFFE);
        check("wrap_addr2", seen_addr[2], 32'hFFFF_FFFF);
        check("wrap_addr3", seen_addr[3], 32'h0000_0000);
        check("wrap_addr4", seen_addr[4], 32'h0000_0001);
        check("wrap_idata", i_data, 32'h00E2_E1F0);
        txn(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 2'd1, 0, rc);
        check("wrap_half", d_rdata, 32'h0000_E2E1);

        // simultaneous instruction word read and data byte read
        @(negedge clock); #1;
        i_read = 1'b1; i_addr = 32'h104; d_read = 1'b1; d_addr = 32'h2001; d_len = 2'd0;
        ci = 0; cd = 0;
        for (int k = 1; k <= 40 && (ci == 0 || cd == 0); k++) begin
            @(negedge clock);
            if (i_ready) ci = k;
            if (d_ready) cd = k;
            #1;
            if (ci == k) i_read = 1'b0;
            if (cd == k) d_read = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;
`ifdef MEMCTRL_DPRIO_EN
        check("dual_first_d", cd, 3);
`else
        check("dual_first_i", ci, 6);
`endif
        check("dual_i_cycle", ci, 10 - ((cd == 10) ? 4 : 0));
        check("dual_d_cycle", cd, (ci == 6) ? 10 : 3);
        check("dual_idata", i_data, 32'h8877_6655);
        check("dual_drdata", d_rdata, 32'h0000_00CC);

        // reset in cycle 3 of a word read, request held through reset
        @(negedge clock); #1;
        i_read = 1'b1; i_addr = 32'h104;
        repeat (3) @(negedge clock);
        #1; reset = 1'b0; #1;
        check("arst_busy", {31'd0, i_busy}, 32'd0);
        check("arst_ready", {31'd0, i_ready}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_idata", i_data, 32'd0);
        @(negedge clock);
        #1; reset = 1'b1;
        rc = 0;
        for (int k = 1; k <= 40 && rc == 0; k++) begin
            @(negedge clock);
            if (i_ready) rc = k;
        end
        #1; i_read = 1'b0;
        check("arst_restart_cycle", rc, 6);
        check("arst_restart_data", i_data, 32'h8877_6655);

        repeat (4) @(negedge clock);
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
